bcd_speed_sched: RTL and testbench
==================================

BCD_SPEED_SCHED -- requirements
Module: bcd_speed_sched

Interface
REQ-001 Parameter FAST_MIN, default 4: minimum remaining distance (mod 10) at which the fast step is issued; legal range 2..9.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  2  per-requester count request; bit i is held high until done[i] or until the requester abandons the request.
REQ-005 tgt0  input  4  BCD target for requester 0; sampled at grant.
REQ-006 tgt1  input  4  BCD target for requester 1; sampled at grant.
REQ-007 y  input  4  current value fed back from the downstream 2-speed BCD counter.
REQ-008 cnt_en  output  1  counter advance enable.
REQ-009 sel  output  1  counter speed; 0 = step +1, 1 = step +2, both mod 10, applied at the next edge when cnt_en=1.
REQ-010 gnt  output  2  one-hot grant; all zero when no requester is granted.
REQ-011 done  output  2  one-cycle completion pulse to the granted requester.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, GRANT, RUN and DONE, encoded in registers.
REQ-014 IDLE: if any req bit is high, the block SHALL choose a winner and go to GRANT at the next edge; otherwise it stays in IDLE.
REQ-015 Arbitration SHALL be round-robin:
  - a 1-bit pointer gives priority to requester ptr;
  - if only one req bit is high, that requester wins regardless of ptr;
  - after each grant, ptr becomes the complement of the winner.
REQ-016 GRANT: gnt SHALL assert for the winner, and the winner's target SHALL be latched into tgt_q.
  - A target value above 9 SHALL be latched as 9.
  - The FSM SHALL advance to RUN at the next edge.
REQ-017 gnt SHALL remain asserted through GRANT, RUN and DONE, and deassert on return to IDLE.
REQ-018 The distance SHALL be computed combinationally as d = (tgt_q - y) mod 10, range 0..9.
REQ-019 RUN, per cycle, decided from y in that same cycle:
  - d=0: cnt_en=0, then DONE next edge;
  - d>=FAST_MIN: cnt_en=1, sel=1;
  - 0<d<FAST_MIN: cnt_en=1, sel=0.
REQ-020 The block SHALL never command a step that overshoots the target; this holds because d=1 always yields sel=0.
REQ-021 Outside RUN, cnt_en SHALL be 0 and sel SHALL be 0.
REQ-022 DONE: done[winner] SHALL be high for exactly one cycle, then the FSM returns to IDLE.
REQ-023 Abort: if req[winner] drops in GRANT or RUN, the block SHALL behave as follows:
  - cnt_en goes to 0 in that same cycle;
  - the FSM returns to IDLE at the next edge;
  - no done pulse is issued;
  - ptr keeps its post-grant value.
REQ-024 A request from the other requester arriving during GRANT, RUN or DONE SHALL be ignored until IDLE, so at most one requester is granted at a time.
REQ-025 The first grant SHALL occur 1 cycle after req rises in IDLE, and the first cnt_en 2 cycles after req rises.
REQ-026 If tgt_q equals y on entry to RUN, the block SHALL spend exactly 1 RUN cycle with cnt_en=0 before entering DONE.

Reset
REQ-027 When rst=1 at an edge, the block SHALL reset as follows:
  - state=IDLE, ptr=0, tgt_q=0;
  - cnt_en=0, sel=0, gnt=00, done=00, busy=0.
REQ-028 Reset SHALL take priority over every other condition.
REQ-029 Reset mid-RUN SHALL drop cnt_en in the next cycle, issue no done pulse, and discard any pending request ordering.
REQ-030 A request held high across the release of rst SHALL be granted 1 cycle after rst falls.

Verification
REQ-031 Basic fast/slow sequencing:
  - stimulus: FAST_MIN=4, y=0, req=01, tgt0=7;
  - RUN sel sequence 1,1,0,0,0 with y going 2,4,5,6,7;
  - then one cycle with cnt_en=0, then a done[0] pulse.
REQ-032 Counter wrap-around:
  - stimulus: y=8, tgt1=3, req=10;
  - fast step to y=0, then slow steps through 1,2,3;
  - no step ever exceeds the remaining distance.
REQ-033 Round-robin arbitration:
  - stimulus: req=11 held continuously, from reset;
  - grants alternate gnt=01, 10, 01 across successive transactions.
REQ-034 Target already reached:
  - stimulus: y=5, tgt0=5;
  - GRANT, then one RUN cycle with cnt_en=0, then DONE;
  - done[0] pulses within 3 cycles of grant.
REQ-035 Abort:
  - stimulus: req[0] dropped during the 2nd RUN cycle;
  - cnt_en=0 in that same cycle, IDLE next edge, done remains 00.
REQ-036 Reset and clamp:
  - stimulus: rst asserted mid-RUN;
  - all outputs are at reset values after that edge;
  - a subsequent tgt0=12 is latched as 9 and the count ends at y=9.

Source files
------------

// File: rtl/bcd_speed_sched.sv
// Round-robin scheduler driving a downstream 2-speed BCD counter.
// One requester at a time is granted. While it is granted, the scheduler steps
// the counter toward that requester's target. It uses +2 steps when the target
// is far away and +1 steps when it is close, so the counter never passes the
// target. Requests that arrive while busy wait until the scheduler is idle.
//
//  state | meaning
//  IDLE  | no grant; arbitrate among pending requests
//  GRANT | winner granted; its target is latched into r_tgt_q at the exit edge
//  RUN   | stepping the counter until the distance to the target is zero
//  DONE  | one-cycle completion pulse to the winner
module bcd_speed_sched #(
  parameter int FAST_MIN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [3:0] tgt0,
  input  logic [3:0] tgt1,
  input  logic [3:0] y,
  output logic       cnt_en,
  output logic       sel,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       busy
);

  localparam logic [3:0] FAST_MIN_L = 4'(FAST_MIN);

  typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_ptr;
  logic       r_win;
  logic [3:0] r_tgt_q;

  logic       w_pick;
  logic       w_win_req;
  logic [1:0] w_onehot;
  logic [3:0] w_tgt_sel;
  logic [3:0] w_tgt_clamp;
  logic [4:0] w_sum;
  logic [3:0] w_dist;

  assign w_win_req   = req[r_win];
  assign w_onehot    = r_win ? 2'b10 : 2'b01;
  assign w_tgt_sel   = r_win ? tgt1 : tgt0;
  assign w_tgt_clamp = (w_tgt_sel > 4'd9) ? 4'd9 : w_tgt_sel;
  // Offset by 20 so that y values above 9 still give a non-negative sum
  assign w_sum       = {1'b0, r_tgt_q} + 5'd20 - {1'b0, y};

  // Round-robin pick: ptr decides only when both requesters are asking
  always_comb begin
    w_pick = 1'b0;
    if (req == 2'b11) w_pick = r_ptr;
    else              w_pick = req[1];
  end

  // Remaining distance (tgt_q - y) mod 10
  always_comb begin
    w_dist = 4'd0;
    if (w_sum >= 5'd20)      w_dist = 4'(w_sum - 5'd20);
    else if (w_sum >= 5'd10) w_dist = 4'(w_sum - 5'd10);
    else                     w_dist = 4'(w_sum);
  end

  // State, winner, pointer and target registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_win   <= 1'b0;
      r_tgt_q <= 4'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req != 2'b00) begin
        r_win <= w_pick;
        r_ptr <= ~w_pick;
      end
      if (r_state == GRANT) r_tgt_q <= w_tgt_clamp;
    end
  end

  // Next-state and output decode; a dropped winner request aborts GRANT/RUN
  always_comb begin
    w_next = r_state;
    cnt_en = 1'b0;
    sel    = 1'b0;
    gnt    = 2'b00;
    done   = 2'b00;
    busy   = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (req != 2'b00) w_next = GRANT;
      end
      GRANT: begin
        gnt = w_onehot;
        if (!w_win_req) w_next = IDLE;
        else            w_next = RUN;
      end
      RUN: begin
        gnt = w_onehot;
        if (!w_win_req) begin
          w_next = IDLE;
        end else if (w_dist == 4'd0) begin
          w_next = DONE;
        end else begin
          cnt_en = 1'b1;
          sel    = (w_dist >= FAST_MIN_L);
        end
      end
      DONE: begin
        gnt    = w_onehot;
        done   = w_onehot;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bcd_speed_sched.sv
// Scoreboard bench for bcd_speed_sched. The bench also models the downstream
// counter. A transaction-level reference model predicts, for each grant, which
// requester wins, the final counter value, the number of steps, and the cycle
// count from grant to done.
module tb_bcd_speed_sched;

  localparam int FAST_MIN = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [3:0] tgt0, tgt1, y;
  logic       cnt_en, sel, busy;
  logic [1:0] gnt, done;

  logic       load;
  logic [3:0] y_init;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int win;
    int tgt;
    int steps;
    int lat;
  } exp_t;

  exp_t q[$];
  int   ptr_m;

  int sel_exp[5] = '{1, 1, 0, 0, 0};
  int y_exp[5]   = '{0, 2, 4, 5, 6};

  bcd_speed_sched #(.FAST_MIN(FAST_MIN)) dut (
    .clk(clk), .rst(rst), .req(req), .tgt0(tgt0), .tgt1(tgt1), .y(y),
    .cnt_en(cnt_en), .sel(sel), .gnt(gnt), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Downstream 2-speed BCD counter
  always @(posedge clk) begin
    if (load)        y <= y_init;
    else if (cnt_en) y <= 4'((int'(y) + (sel ? 2 : 1)) % 10);
  end

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: arbitrate, clamp the target, then count greedy steps
  task automatic push_exp(input logic [1:0] rb, input int t0, input int t1,
                          input int y0, input bit do_push);
    exp_t e;
    int   d;
    e.win = (rb == 2'b11) ? ptr_m : ((rb == 2'b10) ? 1 : 0);
    ptr_m = 1 - e.win;
    e.tgt = (e.win == 1) ? t1 : t0;
    if (e.tgt > 9) e.tgt = 9;
    d = (e.tgt - y0 + 10) % 10;
    e.steps = 0;
    while (d > 0) begin
      d = d - ((d >= FAST_MIN) ? 2 : 1);
      e.steps++;
    end
    e.lat = e.steps + 3;
    if (do_push) q.push_back(e);
  endtask

  // Monitor: per-cycle invariants, step safety, and scoreboard pop on done
  int  mon_cyc = 0;
  int  mon_steps = 0;
  bit  mon_active = 0;
  always @(negedge clk) begin
    exp_t e;
    int   rem;
    if (rst) begin
      mon_active = 0;
    end else begin
      chk(!(sel && !cnt_en), "sel_without_en", int'(sel), 0);
      chk(gnt != 2'b11, "gnt_onehot", int'(gnt), 1);
      chk(busy == (gnt != 2'b00), "busy_vs_gnt", int'(busy), int'(gnt != 2'b00));
      if (gnt != 2'b00) begin
        if (!mon_active) begin
          mon_active = 1;
          mon_cyc    = 0;
          mon_steps  = 0;
        end
        mon_cyc++;
        if (cnt_en) mon_steps++;
      end else begin
        mon_active = 0;
      end
      if (cnt_en && q.size() > 0) begin
        rem = (q[0].tgt - int'(y) + 10) % 10;
        chk((sel ? 2 : 1) <= rem, "step_overshoot", sel ? 2 : 1, rem);
      end
      if (done != 2'b00) begin
        if (q.size() == 0) begin
          chk(0, "unexpected_done", int'(done), 0);
        end else begin
          e = q.pop_front();
          chk(done == ((e.win == 1) ? 2'b10 : 2'b01), "done_winner", int'(done), e.win);
          chk(gnt == done, "gnt_at_done", int'(gnt), int'(done));
          chk(int'(y) == e.tgt, "final_y", int'(y), e.tgt);
          chk(mon_steps == e.steps, "step_count", mon_steps, e.steps);
          chk(mon_cyc == e.lat, "grant_to_done", mon_cyc, e.lat);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk(0, "idle_timeout", int'(busy), 0);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == 2'b00 && n < 80);
    if (done == 2'b00) chk(0, "done_timeout", n, 80);
  endtask

  task automatic do_txn(input logic [1:0] rb, input int t0, input int t1, input int y0);
    wait_idle();
    load   = 1'b1;
    y_init = 4'(y0);
    tgt0   = 4'(t0);
    tgt1   = 4'(t1);
    req    = rb;
    push_exp(rb, t0, t1, y0, 1'b1);
    @(negedge clk);
    load = 1'b0;
    wait_done();
    req = 2'b00;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(cnt_en == 1'b0, {tag, "_cnt_en"}, int'(cnt_en), 0);
    chk(sel == 1'b0,    {tag, "_sel"},    int'(sel), 0);
    chk(gnt == 2'b00,   {tag, "_gnt"},    int'(gnt), 0);
    chk(done == 2'b00,  {tag, "_done"},   int'(done), 0);
    chk(busy == 1'b0,   {tag, "_busy"},   int'(busy), 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst   = 1'b0;
    ptr_m = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 2'b00; tgt0 = 4'd0; tgt1 = 4'd0;
    load = 1'b1; y_init = 4'd0; ptr_m = 0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("init");
    rst = 1'b0; load = 1'b0;

    // Fast/slow sequencing with exact cycle-by-cycle expectations
    @(negedge clk);
    load = 1'b1; y_init = 4'd0; tgt0 = 4'd7; req = 2'b01;
    push_exp(2'b01, 7, 0, 0, 1'b1);
    @(negedge clk);
    load = 1'b0;
    chk(gnt == 2'b01, "first_gnt", int'(gnt), 1);
    chk(cnt_en == 1'b0, "grant_cnt_en", int'(cnt_en), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(cnt_en == 1'b1, "seq_cnt_en", int'(cnt_en), 1);
      chk(int'(sel) == sel_exp[i], "seq_sel", int'(sel), sel_exp[i]);
      chk(int'(y) == y_exp[i], "seq_y", int'(y), y_exp[i]);
    end
    @(negedge clk);
    chk(cnt_en == 1'b0, "seq_idle_run", int'(cnt_en), 0);
    chk(y == 4'd7, "seq_y_final", int'(y), 7);
    @(negedge clk);
    chk(done == 2'b01, "seq_done", int'(done), 1);
    req = 2'b00;

    // Wrap-around and already-at-target
    do_txn(2'b10, 0, 3, 8);
    do_txn(2'b01, 5, 0, 5);

    // Round robin with both requests held continuously from reset
    apply_reset();
    load = 1'b1; y_init = 4'd0; tgt0 = 4'd3; tgt1 = 4'd6; req = 2'b11;
    push_exp(2'b11, 3, 6, 0, 1'b1);
    push_exp(2'b11, 3, 6, 3, 1'b1);
    push_exp(2'b11, 3, 6, 6, 1'b1);
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 3; k++) wait_done();
    req = 2'b00;

    // Abort in the second RUN cycle
    wait_idle();
    load = 1'b1; y_init = 4'd0; tgt0 = 4'd9; req = 2'b01;
    push_exp(2'b01, 9, 0, 0, 1'b0);
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk(cnt_en == 1'b1, "abort_pre_en", int'(cnt_en), 1);
    req = 2'b00;
    #1;
    chk(cnt_en == 1'b0, "abort_cnt_en", int'(cnt_en), 0);
    @(negedge clk);
    chk(busy == 1'b0, "abort_idle", int'(busy), 0);
    chk(gnt == 2'b00, "abort_gnt", int'(gnt), 0);
    // Pointer still holds its post-grant value, so requester 1 wins the tie
    do_txn(2'b11, 2, 4, 0);

    // Reset mid-RUN with the request held, then a clamped target
    wait_idle();
    load = 1'b1; y_init = 4'd0; tgt0 = 4'd8; req = 2'b01;
    push_exp(2'b01, 8, 0, 0, 1'b0);
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; tgt0 = 4'd12; load = 1'b1; y_init = 4'd0;
    @(negedge clk);
    chk_reset_outputs("midrun_rst");
    rst = 1'b0; load = 1'b0; ptr_m = 0;
    push_exp(2'b01, 12, 0, 0, 1'b1);
    @(negedge clk);
    chk(gnt == 2'b01, "gnt_after_rst", int'(gnt), 1);
    wait_done();
    req = 2'b00;

    // Randomized transactions
    for (int r = 0; r < 12; r++) begin
      do_txn(2'($urandom_range(1, 3)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 9)));
    end

    repeat (3) @(negedge clk);
    chk(q.size() == 0, "scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
